// File: rtl/bus_arbiter_2to1.sv
// bus_arbiter_2to1: two-requester round-robin arbiter in front of the
// interconnect's s0 slave port. A grant covers exactly one transfer and
// always returns through IDLE. Downstream command, read data and
// response pass through combinationally while a grant is held.
// Optional macro ARB_TIMEOUT_EN adds a stall timeout that ends a hung
// transfer with an error response (2'b11).
module bus_arbiter_2to1 #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] u0_bus_addr,
  input  logic              u0_bus_read,
  input  logic              u0_bus_write,
  input  logic [31:0]       u0_bus_writedata,
  input  logic [3:0]        u0_bus_byteenable,
  output logic [31:0]       u0_bus_readdata,
  output logic [1:0]        u0_bus_response,
  output logic              u0_bus_waitrequest,
  input  logic [ADDR_W-1:0] u1_bus_addr,
  input  logic              u1_bus_read,
  input  logic              u1_bus_write,
  input  logic [31:0]       u1_bus_writedata,
  input  logic [3:0]        u1_bus_byteenable,
  output logic [31:0]       u1_bus_readdata,
  output logic [1:0]        u1_bus_response,
  output logic              u1_bus_waitrequest,
  output logic [ADDR_W-1:0] d_bus_addr,
  output logic              d_bus_read,
  output logic              d_bus_write,
  output logic [31:0]       d_bus_writedata,
  output logic [3:0]        d_bus_byteenable,
  input  logic [31:0]       d_bus_readdata,
  input  logic [1:0]        d_bus_response,
  input  logic              d_bus_waitrequest
);

  localparam int unsigned RESP_W = 2;
  localparam logic [RESP_W-1:0] RESP_TMO = 2'b11;

  // The stall counter must be able to reach the timeout value
  if (64'(TIMEOUT_CYCLES) >= (64'(1) << TIMEOUT_W)) begin : g_bad_tmo_cfg
    $error("bus_arbiter_2to1: TIMEOUT_CYCLES does not fit in TIMEOUT_W bits");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;
  logic   req0, req1, gnt0, gnt1, xfer_done, tmo_hit;

  assign req0      = u0_bus_read | u0_bus_write;
  assign req1      = u1_bus_read | u1_bus_write;
  assign gnt0      = (state_q == GNT0);
  assign gnt1      = (state_q == GNT1);
  assign xfer_done = (d_bus_read | d_bus_write) & ~d_bus_waitrequest;

`ifdef ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES));

  // Stall counter: zero while idle so every grant starts from zero
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE) begin
      tmo_cnt_d = '0;
    end else if (d_bus_waitrequest) begin
      tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next state: round-robin pick in IDLE, release after one transfer
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_gnt_q)) begin
          state_d    = GNT0;
          last_gnt_d = 1'b0;
        end else if (req1) begin
          state_d    = GNT1;
          last_gnt_d = 1'b1;
        end
      end
      GNT0:    if (!req0 || xfer_done || tmo_hit) state_d = IDLE;
      GNT1:    if (!req1 || xfer_done || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; last_gnt resets to 1 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  // Pass-through mux; timeout overrides the granted side's completion
  always_comb begin
    d_bus_addr         = '0;
    d_bus_read         = 1'b0;
    d_bus_write        = 1'b0;
    d_bus_writedata    = '0;
    d_bus_byteenable   = '0;
    u0_bus_readdata    = '0;
    u0_bus_response    = '0;
    u0_bus_waitrequest = 1'b1;
    u1_bus_readdata    = '0;
    u1_bus_response    = '0;
    u1_bus_waitrequest = 1'b1;
    if (gnt0) begin
      d_bus_addr         = u0_bus_addr;
      d_bus_read         = u0_bus_read;
      d_bus_write        = u0_bus_write;
      d_bus_writedata    = u0_bus_writedata;
      d_bus_byteenable   = u0_bus_byteenable;
      u0_bus_readdata    = d_bus_readdata;
      u0_bus_response    = d_bus_response;
      u0_bus_waitrequest = d_bus_waitrequest;
      if (tmo_hit) begin
        d_bus_read         = 1'b0;
        d_bus_write        = 1'b0;
        u0_bus_readdata    = '0;
        u0_bus_response    = RESP_TMO;
        u0_bus_waitrequest = 1'b0;
      end
    end
    if (gnt1) begin
      d_bus_addr         = u1_bus_addr;
      d_bus_read         = u1_bus_read;
      d_bus_write        = u1_bus_write;
      d_bus_writedata    = u1_bus_writedata;
      d_bus_byteenable   = u1_bus_byteenable;
      u1_bus_readdata    = d_bus_readdata;
      u1_bus_response    = d_bus_response;
      u1_bus_waitrequest = d_bus_waitrequest;
      if (tmo_hit) begin
        d_bus_read         = 1'b0;
        d_bus_write        = 1'b0;
        u1_bus_readdata    = '0;
        u1_bus_response    = RESP_TMO;
        u1_bus_waitrequest = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Testbench for bus_arbiter_2to1: scoreboard of expected downstream
// transfers per requester, popped when the interconnect model completes.
module tb_bus_arbiter_2to1;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TB_TMO = 8;
`else
  localparam int unsigned TB_TMO = 255;
`endif
  localparam logic [31:0] RD_KEY = 32'h1234_577C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] u0_bus_addr, u1_bus_addr, d_bus_addr;
  logic        u0_bus_read, u0_bus_write, u1_bus_read, u1_bus_write;
  logic [31:0] u0_bus_writedata, u1_bus_writedata, d_bus_writedata;
  logic [3:0]  u0_bus_byteenable, u1_bus_byteenable, d_bus_byteenable;
  logic [31:0] u0_bus_readdata, u1_bus_readdata, d_bus_readdata;
  logic [1:0]  u0_bus_response, u1_bus_response, d_bus_response;
  logic        u0_bus_waitrequest, u1_bus_waitrequest, d_bus_waitrequest;
  logic        d_bus_read, d_bus_write;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } xfer_t;

  xfer_t q0[$];
  xfer_t q1[$];
  int    grant_log[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    stall_cfg = 0;
  int    stall_cnt = 0;

  always #5 clk = ~clk;

  bus_arbiter_2to1 #(.ADDR_W(32), .TIMEOUT_CYCLES(TB_TMO), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .u0_bus_addr(u0_bus_addr), .u0_bus_read(u0_bus_read), .u0_bus_write(u0_bus_write),
    .u0_bus_writedata(u0_bus_writedata), .u0_bus_byteenable(u0_bus_byteenable),
    .u0_bus_readdata(u0_bus_readdata), .u0_bus_response(u0_bus_response),
    .u0_bus_waitrequest(u0_bus_waitrequest),
    .u1_bus_addr(u1_bus_addr), .u1_bus_read(u1_bus_read), .u1_bus_write(u1_bus_write),
    .u1_bus_writedata(u1_bus_writedata), .u1_bus_byteenable(u1_bus_byteenable),
    .u1_bus_readdata(u1_bus_readdata), .u1_bus_response(u1_bus_response),
    .u1_bus_waitrequest(u1_bus_waitrequest),
    .d_bus_addr(d_bus_addr), .d_bus_read(d_bus_read), .d_bus_write(d_bus_write),
    .d_bus_writedata(d_bus_writedata), .d_bus_byteenable(d_bus_byteenable),
    .d_bus_readdata(d_bus_readdata), .d_bus_response(d_bus_response),
    .d_bus_waitrequest(d_bus_waitrequest)
  );

  // Interconnect model: address-derived read data/response, programmable stall
  assign d_bus_readdata    = d_bus_addr ^ RD_KEY;
  assign d_bus_response    = d_bus_addr[3:2];
  assign d_bus_waitrequest = (d_bus_read | d_bus_write) && (stall_cnt < stall_cfg);

  always @(posedge clk) begin
    if (!(d_bus_read | d_bus_write) || !d_bus_waitrequest) stall_cnt <= 0;
    else stall_cnt <= stall_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every completed downstream transfer must match the granted queue head
  always @(negedge clk) begin
    if (rst_n && (d_bus_read | d_bus_write) && !d_bus_waitrequest) begin
      int    id;
      xfer_t e;
      id = u0_bus_waitrequest ? 1 : 0;
      grant_log.push_back(id);
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        chk("sb_unexpected_xfer", 64'(id), 64'(9));
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk("sb_addr",  64'(d_bus_addr), 64'(e.addr));
        chk("sb_write", 64'(d_bus_write), 64'(e.wr));
        chk("sb_read",  64'(d_bus_read), 64'(!e.wr));
        if (e.wr) begin
          chk("sb_wdata", 64'(d_bus_writedata), 64'(e.wdata));
          chk("sb_be",    64'(d_bus_byteenable), 64'(e.be));
        end
        chk("sb_rdata", 64'((id == 0) ? u0_bus_readdata : u1_bus_readdata), 64'(e.addr ^ RD_KEY));
        chk("sb_resp",  64'((id == 0) ? u0_bus_response : u1_bus_response), 64'(e.addr[3:2]));
        chk("sb_other_wait", 64'((id == 0) ? u1_bus_waitrequest : u0_bus_waitrequest), 64'(1));
      end
    end
  end

  task automatic set_req(input int id, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    if (id == 0) begin
      u0_bus_read = rd; u0_bus_write = wr; u0_bus_addr = a;
      u0_bus_writedata = wd; u0_bus_byteenable = be;
    end else begin
      u1_bus_read = rd; u1_bus_write = wr; u1_bus_addr = a;
      u1_bus_writedata = wd; u1_bus_byteenable = be;
    end
  endtask

  // Called just after a rising edge; lat = cycles until waitrequest is seen low
  task automatic do_xfer(input int id, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output int lat);
    xfer_t e;
    e = '{addr: a, wr: wr, wdata: wd, be: be};
    if (id == 0) q0.push_back(e); else q1.push_back(e);
    set_req(id, !wr, wr, a, wd, be);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (((id == 0) ? u0_bus_waitrequest : u1_bus_waitrequest) && lat < 200);
    if (lat >= 200) chk("xfer_timeout", 64'(lat), 64'(0));
    @(posedge clk); #1;
    set_req(id, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat0, lat1, base, n0;
    int lats0[4];
    int lats1[4];
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_u0_wait", 64'(u0_bus_waitrequest), 64'(1));
    chk("rst_u1_wait", 64'(u1_bus_waitrequest), 64'(1));
    chk("rst_d_cmd",   64'({d_bus_read, d_bus_write}), 64'(0));
    chk("rst_d_addr",  64'(d_bus_addr), 64'(0));
    do_reset();

    // Single read from u0 @0x104
    q0.push_back('{addr: 32'h104, wr: 1'b0, wdata: 32'h0, be: 4'h0});
    set_req(0, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
    @(negedge clk);
    chk("t1_c1_u0_wait", 64'(u0_bus_waitrequest), 64'(1));
    chk("t1_c1_d_read",  64'(d_bus_read), 64'(0));
    chk("t1_c1_d_addr",  64'(d_bus_addr), 64'(0));
    chk("t1_c1_u1_wait", 64'(u1_bus_waitrequest), 64'(1));
    @(negedge clk);
    chk("t1_c2_u0_wait",  64'(u0_bus_waitrequest), 64'(0));
    chk("t1_c2_u0_rdata", 64'(u0_bus_readdata), 64'(32'h1234_5678));
    chk("t1_c2_u0_resp",  64'(u0_bus_response), 64'(1));
    chk("t1_c2_d_read",   64'(d_bus_read), 64'(1));
    chk("t1_c2_u1_wait",  64'(u1_bus_waitrequest), 64'(1));
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("t1_c3_u0_wait", 64'(u0_bus_waitrequest), 64'(1));

    // Simultaneous requests after reset: u0 write first, u1 read after IDLE
    do_reset();
    base = grant_log.size();
    fork
      do_xfer(0, 1'b1, 32'h200, 32'hA5A5_A5A5, 4'hF, lat0);
      do_xfer(1, 1'b0, 32'h300, 32'h0, 4'h0, lat1);
    join
    chk("t2_lat0", 64'(lat0), 64'(2));
    chk("t2_lat1", 64'(lat1), 64'(4));
    chk("t2_order0", 64'(grant_log[base]), 64'(0));
    chk("t2_order1", 64'(grant_log[base + 1]), 64'(1));

    // Continuous requests from both: strict alternation
    base = grant_log.size();
    fork
      for (int i = 0; i < 4; i++)
        do_xfer(0, 1'(i % 2), 32'h1000 + 32'(i * 4), 32'hC000_0000 + 32'(i), 4'(i + 1), lats0[i]);
      for (int i = 0; i < 4; i++)
        do_xfer(1, 1'((i + 1) % 2), 32'h2000 + 32'(i * 4), 32'hD000_0000 + 32'(i), 4'(8 - i), lats1[i]);
    join
    chk("t3_count", 64'(grant_log.size() - base), 64'(8));
    n0 = 0;
    for (int i = 0; i < 8 && base + i < grant_log.size(); i++) begin
      chk("t3_alt", 64'(grant_log[base + i]), 64'(i % 2));
      if (grant_log[base + i] == 0) n0++;
    end
    chk("t3_u0_count", 64'(n0), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk("t3_lat0", 64'(lats0[i]), 64'((i == 0) ? 2 : 4));
      chk("t3_lat1", 64'(lats1[i]), 64'(4));
    end

    // Downstream stall of 5 cycles on a u1 write, u0 queued behind it
    stall_cfg = 5;
    base = grant_log.size();
    fork
      do_xfer(1, 1'b1, 32'h340, 32'h5A5A_0001, 4'h3, lat1);
      begin
        @(posedge clk); #1;
        do_xfer(0, 1'b0, 32'h108, 32'h0, 4'h0, lat0);
      end
    join
    chk("t4_lat1", 64'(lat1), 64'(7));
    chk("t4_lat0", 64'(lat0), 64'(13));
    chk("t4_order0", 64'(grant_log[base]), 64'(1));
    chk("t4_order1", 64'(grant_log[base + 1]), 64'(0));

    // Reset in the middle of a stalled u0 grant
    stall_cfg = 10;
    set_req(0, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_pre_d_read", 64'(d_bus_read), 64'(1));
    chk("t5_pre_u0_wait", 64'(u0_bus_waitrequest), 64'(1));
    @(negedge clk);
    chk("t5_d_read",  64'(d_bus_read), 64'(0));
    chk("t5_u0_wait", 64'(u0_bus_waitrequest), 64'(1));
    chk("t5_u1_wait", 64'(u1_bus_waitrequest), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    stall_cfg = 0;
    base = grant_log.size();
    fork
      do_xfer(0, 1'b0, 32'h600, 32'h0, 4'h0, lat0);
      do_xfer(1, 1'b1, 32'h704, 32'h0BAD_F00D, 4'hC, lat1);
    join
    chk("t5_lat0", 64'(lat0), 64'(2));
    chk("t5_lat1", 64'(lat1), 64'(4));
    chk("t5_first", 64'(grant_log[base]), 64'(0));

    // Requester drops its command while granted
    stall_cfg = 3;
    set_req(1, 1'b1, 1'b0, 32'h710, 32'h0, 4'hF);
    @(negedge clk);
    @(posedge clk); #1;
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("t6_d_read_drop", 64'(d_bus_read), 64'(0));
    @(negedge clk);
    chk("t6_u1_wait_idle", 64'(u1_bus_waitrequest), 64'(1));
    stall_cfg = 0;
    @(posedge clk); #1;
    do_xfer(0, 1'b1, 32'h800, 32'h1111_2222, 4'h1, lat0);
    chk("t6_lat0", 64'(lat0), 64'(2));

`ifdef ARB_TIMEOUT_EN
    // Downstream stuck in waitrequest: timeout releases u0 with error
    stall_cfg = 1000;
    set_req(0, 1'b1, 1'b0, 32'h900, 32'h0, 4'hF);
    lat0 = 0;
    do begin
      @(negedge clk);
      lat0++;
    end while (u0_bus_waitrequest && lat0 < 300);
    chk("t7_lat",   64'(lat0), 64'(TB_TMO + 2));
    chk("t7_resp",  64'(u0_bus_response), 64'(3));
    chk("t7_rdata", 64'(u0_bus_readdata), 64'(0));
    chk("t7_d_read", 64'(d_bus_read), 64'(0));
    @(negedge clk);
    chk("t7_idle_u0_wait", 64'(u0_bus_waitrequest), 64'(1));
    chk("t7_idle_d_read",  64'(d_bus_read), 64'(0));
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    stall_cfg = 0;
`endif

    repeat (3) @(posedge clk);
    chk("sb_q0_empty", 64'(q0.size()), 64'(0));
    chk("sb_q1_empty", 64'(q1.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
